regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2: number of read ports.
REQ-004 SHALL have parameter NUM_WR, default 2: number of write ports; a higher index has higher priority.
REQ-005 SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-006 Ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ra  in  NUM_RD x ADDR_W  read addresses
- rd  out  NUM_RD x DATA_W  read data
- rd_busy  out  NUM_RD  source register has a pending write
- we  in  NUM_WR  write enables
- wa  in  NUM_WR x ADDR_W  write addresses
- wd  in  NUM_WR x DATA_W  write data
- rsv_valid  in  1  request to reserve a destination register
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ready  out  1  reservation accepted this cycle
- pend_cnt  out  ADDR_W+1  number of reserved (busy) registers

Function
REQ-007 SHALL perform writes on the rising clk edge when we[i]=1; a write to address 0 SHALL be discarded.
REQ-008 SHALL force rd[j]=0 and rd_busy[j]=0 whenever ra[j]=0.
REQ-009 SHALL bypass writes combinationally: if we[i]=1 and wa[i]=ra[j]!=0, rd[j] SHALL equal wd[i] in the same cycle.
REQ-010 When several ports write the same address in one cycle, the highest-index port SHALL win for both the stored value and the bypass.
REQ-011 SHALL keep one busy bit per register; busy[0] SHALL be constantly 0.
REQ-012 rsv_ready SHALL be 1 iff rsv_valid=1 and (rsv_addr=0 or busy[rsv_addr]=0); this is combinational.
REQ-013 When rsv_valid and rsv_ready are both 1 and rsv_addr!=0, busy[rsv_addr] SHALL be set at the next edge.
REQ-014 Any write with we[i]=1 to address a SHALL clear busy[a] at the next edge.
REQ-015 If an accepted reservation and a write target the same address in one cycle, the reservation SHALL win and busy SHALL end at 1.
REQ-016 rd_busy[j] SHALL be busy[ra[j]] AND NOT (a same-cycle write to ra[j]).
REQ-017 pend_cnt SHALL be a registered count, updated each edge by +1 for a set, -1 for each distinct clear, and net 0 for the REQ-015 case; it SHALL never exceed 2**ADDR_W-1.
REQ-018 Writes to a non-busy register SHALL be legal, SHALL update data, and SHALL leave busy unchanged.

Reset
REQ-019 While reset=1, all registers, all busy bits and pend_cnt SHALL be 0 asynchronously; rd and rd_busy SHALL read 0.
REQ-020 Writes and reservations presented during reset SHALL be ignored. The first edge after reset deasserts SHALL act normally.

Structure
REQ-021 DATA_W/ADDR_W defaults and the port-count types SHALL live in a shared package, regfile_pkg.
REQ-022 The busy-bit array plus pend_cnt SHALL be one sub-module, reg_scoreboard; the data array and bypass muxes SHALL stay in the top module.

Verification
REQ-023 Reset check: assert reset mid-run after writing 0xDEADBEEF to r5. Then ra0=5 SHALL give rd0=0, rd_busy0=0 and pend_cnt=0.
REQ-024 Bypass check: we0=1, wa0=7, wd0=0x12345678, ra1=7. rd1 SHALL be 0x12345678 in the same cycle and SHALL remain so on the next cycle.
REQ-025 Port priority check: we0=we1=1, wa0=wa1=3, wd0=0x1, wd1=0x2. rd SHALL be 0x2 in the same cycle and after the edge.
REQ-026 Scoreboard check:
- reserve r9: rsv_ready=1, then pend_cnt=1 and rd_busy=1 for ra=9
- re-reserve r9: rsv_ready=0
- write r9: rd_busy drops in the same cycle and pend_cnt=0 next
REQ-027 Collision check: with r4 idle, present a reserve of r4 and a write to r4 in the same cycle. busy[4]=1, pend_cnt=1 and stored value=wd afterward.
REQ-028 r0 check: write 0xFFFFFFFF to r0 and reserve r0. rsv_ready=1, rd=0, rd_busy=0 and pend_cnt unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared parameters and types for the register file with scoreboard.
// Holds the default geometry used by the top, the interface and the scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;
    localparam int NUM_WR_DEF = 2;

    typedef logic [NUM_RD_DEF-1:0] rd_mask_t;
    typedef logic [NUM_WR_DEF-1:0] wr_mask_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundle of read, write and reservation signals of the register file.
// The slave side is the register file, the master side is the pipeline.
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF
);

    logic [NUM_RD-1:0][ADDR_W-1:0] ra;
    logic [NUM_RD-1:0][DATA_W-1:0] rd;
    logic [NUM_RD-1:0]             rd_busy;
    logic [NUM_WR-1:0]             we;
    logic [NUM_WR-1:0][ADDR_W-1:0] wa;
    logic [NUM_WR-1:0][DATA_W-1:0] wd;
    logic                          rsv_valid;
    logic [ADDR_W-1:0]             rsv_addr;
    logic                          rsv_ready;
    logic [ADDR_W:0]               pend_cnt;

    modport master (
        output ra, we, wa, wd, rsv_valid, rsv_addr,
        input  rd, rd_busy, rsv_ready, pend_cnt
    );

    modport slave (
        input  ra, we, wa, wd, rsv_valid, rsv_addr,
        output rd, rd_busy, rsv_ready, pend_cnt
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register plus a count.
// A reservation beats a same-cycle write to the same register.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_WR = NUM_WR_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_WR-1:0]             we,
    input  logic [NUM_WR-1:0][ADDR_W-1:0] wa,
    input  logic                          rsv_valid,
    input  logic [ADDR_W-1:0]             rsv_addr,
    output logic                          rsv_ready,
    output logic [2**ADDR_W-1:0]          busy,
    output logic [ADDR_W:0]               pend_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] clr;
    logic [DEPTH-1:0] set;
    logic [DEPTH-1:0] busy_next;
    logic [ADDR_W:0]  cnt_next;

    // Accept a reservation of r0 or of any register not already pending.
    always_comb begin
        rsv_ready = rsv_valid && ((rsv_addr == '0) || !busy[rsv_addr]);
    end

    // Next busy vector and its population count; set wins over clear.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (we[i]) clr[wa[i]] = 1'b1;
        end
        set = '0;
        if (rsv_ready && (rsv_addr != '0)) set[rsv_addr] = 1'b1;
        busy_next = (busy & ~clr) | set;
        busy_next[0] = 1'b0;
        cnt_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[k]};
        end
    end

    // Busy bits and pending count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_next;
            pend_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write bypass and a busy-bit scoreboard.
// r0 reads as zero; the highest-index write port wins on address clashes.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF
) (
    input logic                 clk,
    input logic                 reset,
    regfile_scoreboard_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             busy;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_val;
    logic [NUM_RD-1:0]             rd_bsy;

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .we        (bus.we),
        .wa        (bus.wa),
        .rsv_valid (bus.rsv_valid),
        .rsv_addr  (bus.rsv_addr),
        .rsv_ready (bus.rsv_ready),
        .busy      (busy),
        .pend_cnt  (bus.pend_cnt)
    );

    // Register array write; later ports overwrite earlier ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (bus.we[i] && (bus.wa[i] != '0)) begin
                    mem[bus.wa[i]] <= bus.wd[i];
                end
            end
        end
    end

    // Read muxes with same-cycle bypass; a bypassed write hides busy.
    always_comb begin : read_mux
        logic [DATA_W-1:0] data;
        logic              hit;
        rd_val = '0;
        rd_bsy = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            data = mem[bus.ra[j]];
            hit  = 1'b0;
            for (int i = 0; i < NUM_WR; i++) begin
                if (bus.we[i] && (bus.wa[i] == bus.ra[j])) begin
                    data = bus.wd[i];
                    hit  = 1'b1;
                end
            end
            if (!reset && (bus.ra[j] != '0)) begin
                rd_val[j] = data;
                rd_bsy[j] = busy[bus.ra[j]] & ~hit;
            end
        end
    end

    // Drive the read side of the bundle.
    always_comb begin
        bus.rd      = rd_val;
        bus.rd_busy = rd_bsy;
    end

endmodule
